// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer.
// Default widths and the per-channel holding state encoding.
package demux_pkg;

  localparam int unsigned N_BIT_DEFAULT   = 32;
  localparam int unsigned CNT_BIT_DEFAULT = 16;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux_channel.sv
// One output channel: one-entry holding register, EMPTY/FULL state and
// a wrapping delivery counter, all cleared synchronously by clear.
module demux_channel
  import demux_pkg::*;
#(
  parameter int unsigned N_BIT   = N_BIT_DEFAULT,
  parameter int unsigned CNT_BIT = CNT_BIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [N_BIT-1:0]   load_data,
  input  logic               sink_ready,
  output logic               valid,
  output logic [N_BIT-1:0]   data,
  output logic [CNT_BIT-1:0] count
);

  localparam logic [CNT_BIT-1:0] CntOne = CNT_BIT'(1);

  ch_state_e          state_q, state_d;
  logic [N_BIT-1:0]   data_q, data_d;
  logic [CNT_BIT-1:0] count_q, count_d;
  logic               pop;

  assign pop = (state_q == CH_FULL) && sink_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      state_d = CH_EMPTY;
      data_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        CH_EMPTY: begin
          if (load) begin
            state_d = CH_FULL;
            data_d  = load_data;
          end
        end
        CH_FULL: begin
          // load is only granted here when the sink pops in the same cycle
          if (load) begin
            data_d = load_data;
          end else if (pop) begin
            state_d = CH_EMPTY;
          end
        end
        default: state_d = CH_EMPTY;
      endcase
      if (pop) begin
        count_d = count_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid = (state_q == CH_FULL);
  assign data  = data_q;
  assign count = count_q;

endmodule

// File: rtl/demux_32_bit_reg.sv
// Registered 1-to-2 demultiplexer with per-channel valid/ready holding
// registers; the top only decodes the select and forms out_ready.
module demux_32_bit_reg
  import demux_pkg::*;
#(
  parameter int unsigned N_BIT   = N_BIT_DEFAULT,
  parameter int unsigned CNT_BIT = CNT_BIT_DEFAULT
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic               in_clear,
  input  logic               in_valid,
  output logic               out_ready,
  input  logic               in_control,
  input  logic [N_BIT-1:0]   in_data,
  output logic               out_valid_0,
  output logic               out_valid_1,
  input  logic               in_ready_0,
  input  logic               in_ready_1,
  output logic [N_BIT-1:0]   out_data_0,
  output logic [N_BIT-1:0]   out_data_1,
  output logic [CNT_BIT-1:0] out_count_0,
  output logic [CNT_BIT-1:0] out_count_1
);

  logic sel_full;
  logic sel_sink_ready;
  logic accept;
  logic load_0;
  logic load_1;

  always_comb begin
    sel_full       = in_control ? out_valid_1 : out_valid_0;
    sel_sink_ready = in_control ? in_ready_1  : in_ready_0;
  end

  // Only the selected channel can stall the source; clear blocks acceptance.
  assign out_ready = !in_clear && (!sel_full || sel_sink_ready);
  assign accept    = in_valid && out_ready;
  assign load_0    = accept && !in_control;
  assign load_1    = accept && in_control;

  demux_channel #(
    .N_BIT   (N_BIT),
    .CNT_BIT (CNT_BIT)
  ) u_channel_0 (
    .clk        (in_clk),
    .rst_n      (in_rst_n),
    .clear      (in_clear),
    .load       (load_0),
    .load_data  (in_data),
    .sink_ready (in_ready_0),
    .valid      (out_valid_0),
    .data       (out_data_0),
    .count      (out_count_0)
  );

  demux_channel #(
    .N_BIT   (N_BIT),
    .CNT_BIT (CNT_BIT)
  ) u_channel_1 (
    .clk        (in_clk),
    .rst_n      (in_rst_n),
    .clear      (in_clear),
    .load       (load_1),
    .load_data  (in_data),
    .sink_ready (in_ready_1),
    .valid      (out_valid_1),
    .data       (out_data_1),
    .count      (out_count_1)
  );

endmodule

// File: tb/tb_demux_32_bit_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based model of the two channels.
module tb_demux_32_bit_reg;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_clear;
  logic        in_valid;
  logic        out_ready;
  logic        in_control;
  logic [31:0] in_data;
  logic        out_valid_0, out_valid_1;
  logic        in_ready_0, in_ready_1;
  logic [31:0] out_data_0, out_data_1;
  logic [15:0] out_count_0, out_count_1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each channel is a queue of at most one word plus the last word
  // loaded (which the data output shows) and a modulo-2^16 pop count.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] m_last [2];
  logic [15:0] m_count [2];
  logic        last_ready;

  demux_32_bit_reg dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_clear    (in_clear),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_control  (in_control),
    .in_data     (in_data),
    .out_valid_0 (out_valid_0),
    .out_valid_1 (out_valid_1),
    .in_ready_0  (in_ready_0),
    .in_ready_1  (in_ready_1),
    .out_data_0  (out_data_0),
    .out_data_1  (out_data_1),
    .out_count_0 (out_count_0),
    .out_count_1 (out_count_1)
  );

  always #5 in_clk = ~in_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_last[k]  = '0;
      m_count[k] = '0;
    end
  endtask

  task automatic check_outputs();
    check_eq("valid_0", 64'(out_valid_0), 64'(mq0.size() != 0));
    check_eq("valid_1", 64'(out_valid_1), 64'(mq1.size() != 0));
    check_eq("data_0",  64'(out_data_0),  64'(m_last[0]));
    check_eq("data_1",  64'(out_data_1),  64'(m_last[1]));
    check_eq("count_0", 64'(out_count_0), 64'(m_count[0]));
    check_eq("count_1", 64'(out_count_1), 64'(m_count[1]));
  endtask

  // One clock: drive on the falling edge, check out_ready before the rising
  // edge, advance the model on the rising edge, check registered outputs after.
  task automatic cycle(input logic v, input logic c, input logic [31:0] d,
                       input logic r0, input logic r1, input logic clr, input bit chk);
    logic exp_ready, acc, pop0, pop1;
    logic [31:0] w;
    @(negedge in_clk);
    in_valid = v; in_control = c; in_data = d;
    in_ready_0 = r0; in_ready_1 = r1; in_clear = clr;
    #1;
    exp_ready  = !clr && (c ? (mq1.size() == 0 || r1) : (mq0.size() == 0 || r0));
    last_ready = out_ready;
    if (chk) check_eq("out_ready", 64'(out_ready), 64'(exp_ready));
    acc  = v && exp_ready;
    pop0 = (mq0.size() != 0) && r0;
    pop1 = (mq1.size() != 0) && r1;
    @(posedge in_clk);
    if (clr) begin
      model_reset();
    end else begin
      if (pop0) begin w = mq0.pop_front(); m_count[0]++; end
      if (pop1) begin w = mq1.pop_front(); m_count[1]++; end
      if (acc && !c) begin mq0.push_back(d); m_last[0] = d; end
      if (acc && c)  begin mq1.push_back(d); m_last[1] = d; end
    end
    #1;
    if (chk) check_outputs();
  endtask

  initial begin
    in_rst_n = 1'b0; in_clear = 1'b0; in_valid = 1'b0; in_control = 1'b0;
    in_data = '0; in_ready_0 = 1'b0; in_ready_1 = 1'b0;
    model_reset();
    #12;
    check_eq("rst_ready", 64'(out_ready), 64'd1);
    check_outputs();
    @(negedge in_clk);
    in_rst_n = 1'b1;

    // Single word to channel 0, then popped.
    cycle(1'b1, 1'b0, 32'ha, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t1_valid_0", 64'(out_valid_0), 64'd1);
    check_eq("t1_data_0",  64'(out_data_0),  64'ha);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t1_count_0", 64'(out_count_0), 64'd1);
    check_eq("t1_count_1", 64'(out_count_1), 64'd0);
    check_eq("t1_valid_1", 64'(out_valid_1), 64'd0);

    // Channel 1 stalled; channel 0 still accepts.
    cycle(1'b1, 1'b1, 32'hb, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_stall_ready", 64'(last_ready), 64'd0);
    check_eq("t2_hold_data_1", 64'(out_data_1), 64'hb);
    cycle(1'b1, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t2_ch0_ready", 64'(last_ready), 64'd1);
    check_eq("t2_data_0",    64'(out_data_0), 64'h1);

    // Pop and accept on channel 0 in the same cycle.
    cycle(1'b1, 1'b0, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t3_data_0",  64'(out_data_0),  64'h3);
    check_eq("t3_valid_0", 64'(out_valid_0), 64'd1);
    check_eq("t3_count_0", 64'(out_count_0), 64'd2);

    // Give channel 1 a nonzero count, then clear with a word offered.
    cycle(1'b1, 1'b1, 32'hc, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t4_count_1", 64'(out_count_1), 64'd1);
    cycle(1'b1, 1'b0, 32'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t4_clr_ready",   64'(last_ready),  64'd0);
    check_eq("t4_clr_valid_0", 64'(out_valid_0), 64'd0);
    check_eq("t4_clr_valid_1", 64'(out_valid_1), 64'd0);
    check_eq("t4_clr_count_0", 64'(out_count_0), 64'd0);
    check_eq("t4_clr_count_1", 64'(out_count_1), 64'd0);

    // Counter wrap on channel 1: 65535 pops reach all-ones, one more wraps.
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b1, 1'b1, 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_eq("t5_count_max", 64'(out_count_1), 64'hffff);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t5_count_wrap", 64'(out_count_1), 64'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0), 1'b1);
    end

    // Asynchronous reset while channel 1 holds a word.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_pre_data_1", 64'(out_data_1), 64'h4);
    @(negedge in_clk);
    in_valid = 1'b0;
    #2;
    in_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid_1", 64'(out_valid_1), 64'd0);
    check_eq("t6_rst_data_1",  64'(out_data_1),  64'd0);
    model_reset();
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
